// File: rtl/aes_key_pkg.sv
// Shared definitions for the AES key-path arbiter: IP count, key-select
// codes, transfer direction encoding, FSM state encoding and small helpers.
package aes_key_pkg;

  // Number of AXI requesters sharing the AES datapath.
  localparam int NUM_IP = 3;

  // Key-select code width and the codes presented to the key mux.
  localparam int KEY_W = 2;
  typedef logic [KEY_W-1:0] key_code_t;

  localparam key_code_t AES0 = 2'h0;
  localparam key_code_t AES1 = 2'h1;
  localparam key_code_t AES2 = 2'h2;

  // Transfer direction reported alongside the grant.
  localparam logic RD = 1'b0;
  localparam logic WR = 1'b1;

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  // Next IP in round-robin order (0 -> 1 -> 2 -> 0). Anything at or beyond
  // the last real IP wraps to IP0, so an illegal code can never propagate.
  function automatic key_code_t rr_next(input key_code_t idx);
    if (idx >= AES2) begin
      return AES0;
    end
    return key_code_t'(idx + 1'b1);
  endfunction

  // One-hot IP vector to key code. An all-zero vector maps to AES0.
  function automatic key_code_t onehot_to_key(input logic [NUM_IP-1:0] oh);
    if (oh[2]) begin
      return AES2;
    end
    if (oh[1]) begin
      return AES1;
    end
    return AES0;
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational three-way round-robin picker. The search starts at the IP
// after 'last' and wraps; the first requesting IP in that order wins.
module rr_pick3
  import aes_key_pkg::*;
(
  input  logic [NUM_IP-1:0] req,
  input  key_code_t         last,
  output logic [NUM_IP-1:0] win,
  output logic              valid
);

  key_code_t pos0;
  key_code_t pos1;
  key_code_t pos2;

  // Search order: highest priority is the IP right after the previous winner.
  always_comb begin
    pos0 = rr_next(last);
    pos1 = rr_next(pos0);
    pos2 = rr_next(pos1);
  end

  // Each IP wins only if it requests and no IP earlier in the search order does.
  for (genvar gi = 0; gi < NUM_IP; gi++) begin : g_win
    localparam key_code_t ME = key_code_t'(gi);
    assign win[gi] = req[gi] &
                     ((pos0 == ME) |
                      ((pos1 == ME) & ~req[pos0]) |
                      ((pos2 == ME) & ~req[pos0] & ~req[pos1]));
  end

  assign valid = |req;

endmodule

// File: rtl/aes_key_arbiter.sv
// Round-robin arbiter/sequencer granting the shared AES key datapath to one
// of three AXI requesters at a time. Issues a start pulse, holds the grant
// until the datapath reports done, and forces a release with an error pulse
// if the datapath stalls past TIMEOUT_CYCLES.
module aes_key_arbiter
  import aes_key_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arb_en,
  input  logic [NUM_IP-1:0] req_ar,
  input  logic [NUM_IP-1:0] req_aw,
  input  logic              txn_done,
  output logic [NUM_IP-1:0] grant,
  output key_code_t         key_sel,
  output logic              rd_wr,
  output logic              txn_start,
  output logic              busy,
  output logic              timeout_err,
  output key_code_t         err_id
);

  // Counter value at which a stalled transaction is released: the release
  // edge then lands TIMEOUT_CYCLES edges after the start pulse is raised.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  arb_state_t        state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  key_code_t         last_reg;
  logic [NUM_IP-1:0] grant_reg;
  key_code_t         key_sel_reg;
  logic              rd_wr_reg;
  logic              txn_start_reg;
  logic              busy_reg;
  logic              timeout_err_reg;
  key_code_t         err_id_reg;

  logic [NUM_IP-1:0] req_any;
  logic [NUM_IP-1:0] pick_win;
  logic              pick_valid;
  key_code_t         pick_key;
  logic              pick_rd_wr;
  logic              done_rel;
  logic              timeout_rel;

  // An IP is requesting if either its read or write address channel is valid.
  always_comb begin
    req_any = req_ar | req_aw;
  end

  rr_pick3 u_pick (
    .req   (req_any),
    .last  (last_reg),
    .win   (pick_win),
    .valid (pick_valid)
  );

  // Winner's key code and direction; a pending read beats a pending write.
  always_comb begin
    pick_key   = onehot_to_key(pick_win);
    pick_rd_wr = (|(pick_win & req_ar)) ? RD : WR;
  end

  // Release conditions; a done coinciding with the timeout is a clean completion.
  always_comb begin
    done_rel    = ((state_reg == ISSUE) || (state_reg == WAIT)) && txn_done;
    timeout_rel = (state_reg == WAIT) && !txn_done && (cnt_reg == TO_LAST);
  end

  // Sequencer FSM with registered outputs, timeout counter and RR pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      last_reg        <= AES2;
      grant_reg       <= '0;
      key_sel_reg     <= AES0;
      rd_wr_reg       <= RD;
      txn_start_reg   <= 1'b0;
      busy_reg        <= 1'b0;
      timeout_err_reg <= 1'b0;
      err_id_reg      <= AES0;
    end else begin
      txn_start_reg   <= 1'b0;
      timeout_err_reg <= 1'b0;
      if (done_rel || timeout_rel) begin
        // Release: the winner becomes the lowest-priority IP for the next round.
        state_reg <= IDLE;
        cnt_reg   <= '0;
        grant_reg <= '0;
        busy_reg  <= 1'b0;
        last_reg  <= key_sel_reg;
        if (timeout_rel) begin
          timeout_err_reg <= 1'b1;
          err_id_reg      <= key_sel_reg;
        end
      end else begin
        case (state_reg)
          IDLE: begin
            if (arb_en && pick_valid) begin
              grant_reg     <= pick_win;
              key_sel_reg   <= pick_key;
              rd_wr_reg     <= pick_rd_wr;
              busy_reg      <= 1'b1;
              txn_start_reg <= 1'b1;
              state_reg     <= ISSUE;
            end
          end
          ISSUE: begin
            cnt_reg   <= CNT_ONE;
            state_reg <= WAIT;
          end
          WAIT: begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
          default: begin
            state_reg <= IDLE;
          end
        endcase
      end
    end
  end

  assign grant       = grant_reg;
  assign key_sel     = key_sel_reg;
  assign rd_wr       = rd_wr_reg;
  assign txn_start   = txn_start_reg;
  assign busy        = busy_reg;
  assign timeout_err = timeout_err_reg;
  assign err_id      = err_id_reg;

endmodule

// File: tb/tb_aes_key_arbiter.sv
// Self-checking bench for aes_key_arbiter: a cycle-by-cycle vector table
// followed by a hand-written asynchronous-reset sequence.
module tb_aes_key_arbiter;

  logic       clk;
  logic       rst_n;
  logic       arb_en;
  logic [2:0] req_ar;
  logic [2:0] req_aw;
  logic       txn_done;
  logic [2:0] grant;
  logic [1:0] key_sel;
  logic       rd_wr;
  logic       txn_start;
  logic       busy;
  logic       timeout_err;
  logic [1:0] err_id;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst_n;
    logic       en;
    logic [2:0] ar;
    logic [2:0] aw;
    logic       done;
    logic [10:0] expv;   // {grant, key_sel, rd_wr, txn_start, busy, timeout_err, err_id}
  } vec_t;

  vec_t vecs[$];

  aes_key_arbiter #(
    .TIMEOUT_CYCLES (8),
    .CNT_W          (16)
  ) dut (
    .clk         (clk),
    .reset       (rst_n),
    .arb_en      (arb_en),
    .req_ar      (req_ar),
    .req_aw      (req_aw),
    .txn_done    (txn_done),
    .grant       (grant),
    .key_sel     (key_sel),
    .rd_wr       (rd_wr),
    .txn_start   (txn_start),
    .busy        (busy),
    .timeout_err (timeout_err),
    .err_id      (err_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] outs();
    return {grant, key_sel, rd_wr, txn_start, busy, timeout_err, err_id};
  endfunction

  function automatic void add(input logic r, input logic e, input logic [2:0] ar,
                              input logic [2:0] aw, input logic d, input logic [2:0] g,
                              input logic [1:0] ks, input logic rw, input logic st,
                              input logic bz, input logic te, input logic [1:0] eid);
    vec_t v;
    v.rst_n = r;
    v.en    = e;
    v.ar    = ar;
    v.aw    = aw;
    v.done  = d;
    v.expv  = {g, ks, rw, st, bz, te, eid};
    vecs.push_back(v);
  endfunction

  task automatic check(input string nm, input logic [10:0] act, input logic [10:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got g=%b ks=%0d rw=%b st=%b busy=%b terr=%b eid=%0d, want g=%b ks=%0d rw=%b st=%b busy=%b terr=%b eid=%0d",
               nm, act[10:8], act[7:6], act[5], act[4], act[3], act[2], act[1:0],
               expv[10:8], expv[7:6], expv[5], expv[4], expv[3], expv[2], expv[1:0]);
    end else begin
      $display("%s: ok g=%b ks=%0d rw=%b st=%b busy=%b terr=%b eid=%0d",
               nm, act[10:8], act[7:6], act[5], act[4], act[3], act[2], act[1:0]);
    end
  endtask

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    // ---------------- vector table ----------------
    // Basic read grant for IP0, done 4 cycles after start.
    add(1,1,3'b001,3'b000,0, 3'b001,0,0,1,1,0,0);
    for (int i = 0; i < 3; i++) add(1,1,3'b000,3'b000,0, 3'b001,0,0,0,1,0,0);
    add(1,1,3'b000,3'b000,1, 3'b000,0,0,0,0,0,0);
    add(1,1,3'b000,3'b000,0, 3'b000,0,0,0,0,0,0);
    // Reset to restore last=IP2.
    add(0,1,3'b000,3'b000,0, 3'b000,0,0,0,0,0,0);
    // All IPs write; done two cycles after each start: IP0, IP1, IP2, IP0.
    add(1,1,3'b000,3'b111,0, 3'b001,0,1,1,1,0,0);
    add(1,1,3'b000,3'b111,0, 3'b001,0,1,0,1,0,0);
    add(1,1,3'b000,3'b111,1, 3'b000,0,1,0,0,0,0);
    add(1,1,3'b000,3'b111,0, 3'b010,1,1,1,1,0,0);
    add(1,1,3'b000,3'b111,0, 3'b010,1,1,0,1,0,0);
    add(1,1,3'b000,3'b111,1, 3'b000,1,1,0,0,0,0);
    add(1,1,3'b000,3'b111,0, 3'b100,2,1,1,1,0,0);
    add(1,1,3'b000,3'b111,0, 3'b100,2,1,0,1,0,0);
    add(1,1,3'b000,3'b111,1, 3'b000,2,1,0,0,0,0);
    add(1,1,3'b000,3'b111,0, 3'b001,0,1,1,1,0,0);
    add(1,1,3'b000,3'b000,0, 3'b001,0,1,0,1,0,0);
    add(1,1,3'b000,3'b000,1, 3'b000,0,1,0,0,0,0);
    // IP1 read+write: read wins, direction frozen while ar drops mid-WAIT.
    add(1,1,3'b010,3'b010,0, 3'b010,1,0,1,1,0,0);
    add(1,1,3'b000,3'b010,0, 3'b010,1,0,0,1,0,0);
    add(1,1,3'b000,3'b110,0, 3'b010,1,0,0,1,0,0);
    add(1,1,3'b000,3'b110,1, 3'b000,1,0,0,0,0,0);
    // IP2 write, done arriving in ISSUE; then done while idle is ignored.
    add(1,1,3'b000,3'b110,0, 3'b100,2,1,1,1,0,0);
    add(1,1,3'b000,3'b000,1, 3'b000,2,1,0,0,0,0);
    add(1,1,3'b000,3'b000,1, 3'b000,2,1,0,0,0,0);
    // arb_en dropped during IP0's transaction with IP1 waiting.
    add(1,1,3'b001,3'b000,0, 3'b001,0,0,1,1,0,0);
    add(1,0,3'b010,3'b000,0, 3'b001,0,0,0,1,0,0);
    add(1,0,3'b010,3'b000,1, 3'b000,0,0,0,0,0,0);
    add(1,0,3'b010,3'b000,0, 3'b000,0,0,0,0,0,0);
    add(1,0,3'b010,3'b000,0, 3'b000,0,0,0,0,0,0);
    add(1,1,3'b010,3'b000,0, 3'b010,1,0,1,1,0,0);
    add(1,1,3'b000,3'b000,1, 3'b000,1,0,0,0,0,0);
    // IP2 times out 8 cycles after start; IP0 wins next over IP1.
    add(1,1,3'b000,3'b100,0, 3'b100,2,1,1,1,0,0);
    for (int i = 0; i < 7; i++) add(1,1,3'b000,3'b000,0, 3'b100,2,1,0,1,0,0);
    add(1,1,3'b011,3'b000,0, 3'b000,2,1,0,0,1,2);
    add(1,1,3'b011,3'b000,0, 3'b001,0,0,1,1,0,2);
    add(1,1,3'b000,3'b000,1, 3'b000,0,0,0,0,0,2);
    // IP1: done coincides with the timeout cycle, clean completion.
    add(1,1,3'b000,3'b010,0, 3'b010,1,1,1,1,0,2);
    for (int i = 0; i < 7; i++) add(1,1,3'b000,3'b000,0, 3'b010,1,1,0,1,0,2);
    add(1,1,3'b000,3'b000,1, 3'b000,1,1,0,0,0,2);

    // ---------------- initial reset ----------------
    rst_n = 1'b1; arb_en = 1'b0; req_ar = '0; req_aw = '0; txn_done = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("reset", outs(), 11'h000);
    @(negedge clk) rst_n = 1'b1;

    // ---------------- table loop ----------------
    foreach (vecs[i]) begin
      @(negedge clk);
      rst_n    = vecs[i].rst_n;
      arb_en   = vecs[i].en;
      req_ar   = vecs[i].ar;
      req_aw   = vecs[i].aw;
      txn_done = vecs[i].done;
      @(posedge clk);
      #1 check($sformatf("vec%0d", i), outs(), vecs[i].expv);
    end

    // ---------------- async reset during WAIT of IP1 ----------------
    @(negedge clk);
    rst_n = 1'b1; arb_en = 1'b1; req_ar = 3'b000; req_aw = 3'b010; txn_done = 1'b0;
    @(posedge clk);
    #1 check("ares_grant", outs(), {3'b010, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2});
    @(negedge clk) req_aw = 3'b000;
    @(posedge clk);
    #1 check("ares_wait", outs(), {3'b010, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2});
    #2 rst_n = 1'b0;
    #1 check("ares_async", outs(), 11'h000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1 check($sformatf("ares_quiet%0d", c), outs(), 11'h000);
    end
    @(negedge clk) req_ar = 3'b011;
    @(posedge clk);
    #1 check("ares_ip0_first", outs(), {3'b001, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0});
    @(negedge clk) begin req_ar = 3'b000; txn_done = 1'b1; end
    @(posedge clk);
    #1 check("ares_release", outs(), 11'h000);
    @(negedge clk) txn_done = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_key_arbiter.md
Name: aes_key_arbiter

Overview:
- Round-robin arbiter and sequencer sharing the single key-selected AES datapath between three AXI requesters (IP0..IP2).
- Watches each IP's AXI AR/AW valid, grants one IP at a time, drives the key-select code and read/write direction to the key mux/datapath, and issues a start pulse.
- Holds the grant until the datapath signals done or a timeout expires.
- Sits between the IP AXI front-ends and the key-select mux / AES engine.

Parameters:
- TIMEOUT_CYCLES, 256, max cycles from txn_start to txn_done before forced release (legal range 2..65535).
- CNT_W, 16, width of the timeout counter (must satisfy 2^CNT_W > TIMEOUT_CYCLES).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-low reset.
- arb_en  in  1  1 = new grants allowed; 0 = finish current txn, then grant nothing.
- req_ar  in  3  per-IP AXI ar_valid, bit i = IPi.
- req_aw  in  3  per-IP AXI aw_valid, bit i = IPi.
- txn_done  in  1  datapath completion pulse for the granted transaction.
- grant  out  3  one-hot grant; 0 when idle.
- key_sel  out  2  key code: AES0=2'h0, AES1=2'h1, AES2=2'h2.
- rd_wr  out  1  0 = read, 1 = write, for the granted txn.
- txn_start  out  1  one-cycle start pulse to the datapath.
- busy  out  1  high from grant until release.
- timeout_err  out  1  one-cycle pulse on forced release.
- err_id  out  2  key code of the IP that timed out; holds until the next timeout.

Behaviour:
- Reset (async assert, sync deassert by the design's reset synchroniser) values:
  - grant=0, key_sel=AES0, rd_wr=0, txn_start=0, busy=0, timeout_err=0, err_id=0.
  - Round-robin pointer last=IP2, so IP0 has first priority.
  - State IDLE, counter 0.
- Request of IPi = req_ar[i] | req_aw[i].
- Direction for the winner: ar has priority over aw. ar=1 gives rd_wr=0; otherwise rd_wr=1.
- Round robin: search order starts at last+1 mod 3. The winner becomes last when its transaction releases (done or timeout).
- State IDLE:
  - If arb_en=1 and any request is sampled at edge N, then at N+1 grant/key_sel/rd_wr/busy are registered and txn_start=1. Go to ISSUE.
  - Otherwise all outputs hold; key_sel and rd_wr keep their last values.
- State ISSUE (1 cycle):
  - txn_start drops next cycle; counter cleared to 1. Go to WAIT.
  - txn_done sampled in ISSUE counts as completion: go directly to IDLE with release.
- State WAIT:
  - Counter increments each cycle.
  - txn_done=1 gives release at the next edge: grant=0, busy=0, last=winner. Go to IDLE.
  - Counter == TIMEOUT_CYCLES-1 with no done: release as above, plus timeout_err=1 for 1 cycle and err_id=key_sel. Go to IDLE.
  - txn_done and the timeout condition in the same cycle: treat as done, no error.
- Grant is sticky: request or valid changes during ISSUE/WAIT are ignored; rd_wr and key_sel are frozen.
- arb_en=0 mid-transaction does not abort it.
- txn_done while in IDLE is ignored.
- Minimum spacing between grants: 3 cycles (start, done, idle/arb). An IDLE cycle always follows a release.
- Reset asserted mid-transaction: immediate return to reset values; no timeout_err; the datapath is reset by the same net.
- Only IPs 0..2 exist. key_sel never takes 2'h3.

Decomposition:
- Shared package aes_key_pkg:
  - key codes AES0/AES1/AES2 and their width;
  - NUM_IP=3;
  - state encoding IDLE/ISSUE/WAIT;
  - RD=1'b0 / WR=1'b1.
- One sub-module, rr_pick3: combinational round-robin picker. Inputs: 3-bit request and 2-bit last pointer. Outputs: one-hot winner and valid.
- The FSM, timeout counter and output registers stay in aes_key_arbiter.

Test Plan:
- Reset then req_ar=3'b001: grant=001, key_sel=0, rd_wr=0 and txn_start pulse one cycle after the request. txn_done 4 cycles later: grant=000, busy=0 next edge.
- req_aw=3'b111 held with done returned 2 cycles after each start: grants ordered IP0,IP1,IP2,IP0 with rd_wr=1 each time, ≥3 cycles apart.
- IP1 with req_ar=1 and req_aw=1 simultaneously: rd_wr=0. IP1 drops ar and keeps aw mid-WAIT: rd_wr stays 0 until release.
- TIMEOUT_CYCLES=8, grant IP2, no done: release 8 cycles after txn_start, timeout_err pulse, err_id=2, next grant goes to IP0.
- arb_en lowered during WAIT of IP0 with IP1 requesting: IP0 completes normally; IP1 not granted until arb_en=1, then granted next cycle.
- Reset asserted during WAIT of IP1: outputs return to reset values asynchronously with no timeout_err. After release, req from IP1 and IP0 together: IP0 granted first.
